// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, 2-entry {instr, pc} skid buffer toward decode,
// redirect/halt handling. Optional bounds/alignment fault logic under FETCH_BOUNDS_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_address,
    input  logic [31:0] machine_code,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] fetch_count_reg;
    logic [1:0]  count_reg;
    logic [31:0] instr_reg [2];
    logic [31:0] epc_reg   [2];
    logic        halted_reg;
    logic        fault_reg;

    logic        redirect_take;
    logic        deq;
    logic        enq_req;
    logic        enq;
    logic        bounds_fault;
    logic [31:0] target_aligned;

    // Redirects are only honoured while still fetching; HALT freezes the PC.
    assign redirect_take  = redirect_valid && (state_reg != ST_HALT);
    assign target_aligned = redirect_target & 32'hFFFF_FFFC;

    assign if_valid = (count_reg != 2'd0) && !redirect_valid;
    assign deq      = if_valid && if_ready;
    assign enq_req  = (state_reg == ST_RUN) && !redirect_valid && !halt_req
                      && ((count_reg != 2'd2) || deq);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_DEPTH) << 2;
    logic out_of_range;
    logic misaligned;
    assign out_of_range = {1'b0, pc_reg} >= IMEM_LIMIT;
    assign misaligned   = redirect_take && (redirect_target[1:0] != 2'b00);
    assign enq          = enq_req && !out_of_range;
    assign bounds_fault = (enq_req && out_of_range) || misaligned;
`else
    assign enq          = enq_req;
    assign bounds_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= RESET_PC;
            fetch_count_reg <= 32'd0;
            count_reg       <= 2'd0;
            instr_reg[0]    <= 32'd0;
            instr_reg[1]    <= 32'd0;
            epc_reg[0]      <= 32'd0;
            epc_reg[1]      <= 32'd0;
            halted_reg      <= 1'b0;
            fault_reg       <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_BOOT: begin
                    if (bounds_fault) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        state_reg  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_req || bounds_fault) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg  <= ST_HALT;
                    halted_reg <= 1'b1;
                end
            endcase

            if (bounds_fault) begin
                fault_reg <= 1'b1;
            end

            if (redirect_take) begin
                count_reg <= 2'd0;
                pc_reg    <= target_aligned;
            end else begin
                count_reg <= count_reg + {1'b0, enq} - {1'b0, deq};
                // Head always lives in slot 0; a full-buffer dequeue shifts slot 1 down.
                if (deq && count_reg == 2'd2) begin
                    instr_reg[0] <= instr_reg[1];
                    epc_reg[0]   <= epc_reg[1];
                end
                if (enq) begin
                    if (count_reg == 2'd0 || (count_reg == 2'd1 && deq)) begin
                        instr_reg[0] <= machine_code;
                        epc_reg[0]   <= pc_reg;
                    end else begin
                        instr_reg[1] <= machine_code;
                        epc_reg[1]   <= pc_reg;
                    end
                    pc_reg          <= pc_reg + 32'd4;
                    fetch_count_reg <= fetch_count_reg + 32'd1;
                end
            end
        end
    end

    assign pc_address  = pc_reg;
    assign if_instr    = instr_reg[0];
    assign if_pc       = epc_reg[0];
    assign halted      = halted_reg;
    assign fetch_count = fetch_count_reg;
    assign fetch_fault = fault_reg;

endmodule
